// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and data ports,
// data wins in IDLE. Define MEMARB_PERF_EN to get live conflict/stall counters.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [15:0] conflict_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        wr;
    } acc_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    acc_t        acc, acc_n;
    logic        d_req, last;
    logic        grant_i, grant_d;
    logic        if_rdy_raw, d_rdy_raw, mem_wr_raw;
    logic [31:0] if_rdata_raw, d_rdata_raw;

    assign d_req = d_rd | d_wr;
    assign last  = (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            acc   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        acc_n        = acc;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        mem_adr      = '0;
        mem_wdata    = '0;
        mem_rd       = 1'b0;
        mem_wr_raw   = 1'b0;
        if_rdy_raw   = 1'b0;
        d_rdy_raw    = 1'b0;
        if_rdata_raw = '0;
        d_rdata_raw  = '0;

        case (state)
            IDLE: begin
                grant_d = d_req;
                grant_i = if_req & ~d_req;
            end
            BUSY_I: begin
                mem_adr   = acc.adr;
                mem_wdata = acc.wdata;
                mem_rd    = 1'b1;
                if (last) begin
                    if_rdy_raw   = 1'b1;
                    if_rdata_raw = mem_rdata;
                    // The fetch is consumed at this edge; a pending data access
                    // takes over with no idle cycle.
                    grant_d = d_req;
                    if (!d_req) state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            BUSY_D: begin
                mem_adr   = acc.adr;
                mem_wdata = acc.wdata;
                mem_rd    = ~acc.wr;
                if (last) begin
                    d_rdy_raw   = 1'b1;
                    mem_wr_raw  = acc.wr;
                    d_rdata_raw = acc.wr ? 32'h0 : mem_rdata;
                    grant_i     = if_req;
                    if (!if_req) state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Simultaneous rd+wr is latched as a write.
        if (grant_d) begin
            state_n     = BUSY_D;
            cnt_n       = CNT_LOAD;
            acc_n.adr   = d_adr;
            acc_n.wdata = d_wdata;
            acc_n.wr    = d_wr;
        end else if (grant_i) begin
            state_n   = BUSY_I;
            cnt_n     = CNT_LOAD;
            acc_n.adr = if_adr;
            acc_n.wr  = 1'b0;
        end
    end

    // Reset masks the commit strobe so an in-flight write never lands.
    assign mem_wr   = mem_wr_raw & ~rst;
    assign if_ready = if_rdy_raw & ~rst;
    assign d_ready  = d_rdy_raw & ~rst;
    assign if_rdata = rst ? 32'h0 : if_rdata_raw;
    assign d_rdata  = rst ? 32'h0 : d_rdata_raw;
    assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

`ifdef MEMARB_PERF_EN
    logic [15:0] conflict_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 16'h0;
            stall_q    <= 16'h0;
        end else begin
            if (grant_d && if_req && conflict_q != 16'hFFFF)
                conflict_q <= conflict_q + 16'h1;
            if (stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'h1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign stall_cnt    = stall_q;
`else
    assign conflict_cnt = 16'h0;
    assign stall_cnt    = 16'h0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port unified memory (byte-addressed, 32-bit big-endian words) between the pipeline's instruction-fetch port and its MEM-stage data port.
- Sequences each fixed-latency access and drives a combinational stall to the pipeline registers until the requesting port completes.
- Sits between the IF/MEM stages and the memory macro; replaces separate instruction and data memories.

Parameters:
WAIT_CYCLES, 2, memory access latency in cycles (legal range 1..15); ready asserts in the last cycle of the access.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  instruction fetch request; held until if_ready
if_adr  in  32  fetch byte address
if_rdata  out  32  fetched word; valid only while if_ready=1, else 0
if_ready  out  1  fetch completes this cycle
d_rd  in  1  data read request; held until d_ready
d_wr  in  1  data write request; held until d_ready
d_adr  in  32  data byte address
d_wdata  in  32  write data
d_rdata  out  32  read word; valid only while d_ready=1 on a read, else 0
d_ready  out  1  data access completes this cycle
mem_adr  out  32  address to memory
mem_wdata  out  32  write data to memory
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable; memory commits on the rising edge
mem_rdata  in  32  memory combinational read data
stall  out  1  freeze PC and pipeline registers

Behaviour:
- Request definitions: d_req = d_rd | d_wr. d_rd=d_wr=1 is illegal and is treated as a write; d_rdata stays 0.
- States: IDLE, BUSY_I, BUSY_D. A 4-bit down-counter cnt runs in the BUSY states.
- Reset: state=IDLE, cnt=0, latched address/data=0. All outputs are 0 in IDLE, except stall, which follows its equation.
- Grant at a rising edge:
  - In IDLE: d_req wins over if_req (fixed data priority, so the older instruction proceeds).
  - On grant: latch the address (and d_wdata plus a write flag for data), load cnt=WAIT_CYCLES-1, enter BUSY_D or BUSY_I.
- In BUSY:
  - mem_adr = latched address.
  - mem_rd = 1 for reads and fetches, for the whole access.
  - mem_wdata = latched data.
  - mem_wr = 1 only in the final cycle (cnt==0) of a write, so there is exactly one commit edge.
  - Requester inputs are ignored while BUSY; only latched values are used.
- Final cycle (cnt==0):
  - The owning port's ready=1.
  - For reads: rdata = mem_rdata (combinational pass-through).
  - At that edge, the completing port's request is considered consumed. If the other port is requesting, it is granted directly (no bubble), otherwise the state returns to IDLE.
  - A same-port request on the next cycle is arbitrated from IDLE.
- Latency: a request asserted in IDLE at cycle T gives ready in cycle T+WAIT_CYCLES. With WAIT_CYCLES=1, the access occupies one BUSY cycle.
- Stall: stall = (if_req & ~if_ready) | (d_req & ~d_ready), purely combinational.
- Reset mid-access: the state is aborted to IDLE at the reset edge. mem_wr and both ready outputs are forced 0 while rst=1, so an in-flight write never commits.
- Counter: cnt never wraps, because BUSY exits at 0.

Optional Feature:
- Macro MEMARB_PERF_EN.
- Defined:
  - Adds outputs conflict_cnt[15:0] (increments every edge at which if_req and d_req are both 1 and the arbiter grants data).
  - Adds stall_cnt[15:0] (increments every edge with stall=1).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: both ports exist and are tied to 0; no counter registers are inferred.

Test Plan:
- WAIT_CYCLES=2, if_req=1, if_adr=0x10, mem returns 0x8C010004 -> if_ready=1 and if_rdata=0x8C010004 exactly 2 cycles after request; stall=1 for 2 cycles, then 0.
- d_wr=1, d_adr=2000, d_wdata=0xFFFFFFF6, then d_rd at 2000 -> exactly one mem_wr cycle; read returns 0xFFFFFFF6 with d_ready after 2 cycles.
- if_req and d_rd asserted together in IDLE -> data granted first (d_ready at T+2); fetch granted at the same edge with no bubble (if_ready at T+4); conflict_cnt=1 with MEMARB_PERF_EN.
- rst asserted during BUSY_D of a write with cnt==0 -> mem_wr=0, d_ready=0, memory unchanged, state IDLE on the next cycle.
- WAIT_CYCLES=1, alternating if_req/d_rd for 6 requests -> one ready per cycle, no idle cycles while requests are pending.
- d_rd=d_wr=1 -> treated as a write: one mem_wr pulse, d_rdata=0.
